// File: rtl/apb_master_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter_pkg
// Shared constants and types for the APB master arbiter slice.
//   ADDR_WIDTH / DATA_WIDTH / PSTRB_WIDTH : default APB bus geometry
//   NUM_SLAVES                            : number of PSEL lines
//   apb_mst_state_e                       : APB phase of the master FSM
//   slave_sel()                           : two address bits -> one-hot PSEL
// -----------------------------------------------------------------------------
package apb_master_arbiter_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int PSTRB_WIDTH = DATA_WIDTH / 8;
    localparam int NUM_SLAVES  = 4;

    typedef enum logic [1:0] {
        MST_IDLE   = 2'd0,
        MST_SETUP  = 2'd1,
        MST_ACCESS = 2'd2
    } apb_mst_state_e;

    // The top two address bits pick one of four slaves.
    function automatic logic [NUM_SLAVES-1:0] slave_sel(input logic [1:0] code);
        case (code)
            2'd0:    slave_sel = 4'b0001;
            2'd1:    slave_sel = 4'b0010;
            2'd2:    slave_sel = 4'b0100;
            2'd3:    slave_sel = 4'b1000;
            default: slave_sel = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter_if
// Bundles the requester-side handshake and the APB bus of the arbiter.
//   requester side : req_valid/addr/write/wdata/strb/prot in,
//                    req_ack, resp_valid, resp_rdata, resp_err out
//   APB side       : PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB out,
//                    PRDATA, PREADY, PSLVERR in
// Modport master is the arbiter's view; modport slave is the environment's.
// -----------------------------------------------------------------------------
interface apb_master_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = apb_master_arbiter_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = apb_master_arbiter_pkg::DATA_WIDTH
);
    localparam int PSTRB_WIDTH = DATA_WIDTH / 8;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata;
    logic [NUM_REQ*PSTRB_WIDTH-1:0] req_strb;
    logic [NUM_REQ*3-1:0]           req_prot;
    logic [NUM_REQ-1:0]             req_ack;
    logic [NUM_REQ-1:0]             resp_valid;
    logic [DATA_WIDTH-1:0]          resp_rdata;
    logic                           resp_err;

    logic [ADDR_WIDTH-1:0]          PADDR;
    logic [2:0]                     PPROT;
    logic [3:0]                     PSEL;
    logic                           PENABLE;
    logic                           PWRITE;
    logic [DATA_WIDTH-1:0]          PWDATA;
    logic [PSTRB_WIDTH-1:0]         PSTRB;
    logic [DATA_WIDTH-1:0]          PRDATA;
    logic                           PREADY;
    logic                           PSLVERR;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        output req_ack, resp_valid, resp_rdata, resp_err,
        output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        input  req_ack, resp_valid, resp_rdata, resp_err,
        input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
// Combinational round-robin grant. The search starts one above rr_ptr_i and
// wraps, so the last winner has the lowest priority.
//   req_valid_i : request vector
//   rr_ptr_i    : index of the last granted requester
//   grant_o     : one-hot grant
//   grant_idx_o : index of the granted requester
//   grant_any_o : at least one request is pending
// -----------------------------------------------------------------------------
module apb_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDXW-1:0]    rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDXW-1:0]    grant_idx_o,
    output logic               grant_any_o
);

    int cand_s;

    // First pending requester found walking upward from rr_ptr_i + 1.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        cand_s      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = (int'(rr_ptr_i) + i) % NUM_REQ;
            if (!grant_any_o && req_valid_i[cand_s[IDXW-1:0]]) begin
                grant_any_o                  = 1'b1;
                grant_o[cand_s[IDXW-1:0]]    = 1'b1;
                grant_idx_o                  = cand_s[IDXW-1:0];
            end else begin
                grant_any_o = grant_any_o;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
// APB master shared by NUM_REQ requesters. Round-robin arbitration in IDLE,
// then one SETUP cycle and an ACCESS phase held until PREADY. Every output is
// a register.
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   bus (master)  : requester handshake + APB bus, see apb_master_arbiter_if
// Build option: APB_TIMEOUT_EN -- abort ACCESS with an error after
// TIMEOUT_CYCLES cycles without PREADY; otherwise ACCESS waits forever.
// -----------------------------------------------------------------------------
module apb_master_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = apb_master_arbiter_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = apb_master_arbiter_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    apb_master_arbiter_if.master  bus
);
    import apb_master_arbiter_pkg::*;

    localparam int PSTRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDXW        = $clog2(NUM_REQ);

    apb_mst_state_e          state_q, state_d;
    logic [IDXW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]         gidx_q, gidx_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [2:0]              pprot_q, pprot_d;
    logic [3:0]              psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [PSTRB_WIDTH-1:0]  pstrb_q, pstrb_d;
    logic [NUM_REQ-1:0]      req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0]      grant_s;
    logic [IDXW-1:0]         grant_idx_s;
    logic                    grant_any_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic                    tmo_hit_s;

    apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_rr_arbiter (
        .req_valid_i (bus.req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s),
        .grant_any_o (grant_any_s)
    );

    assign sel_addr_s = bus.req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef APB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNTW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Wait counter: cleared entering ACCESS, counts ACCESS cycles without PREADY.
    always_comb begin
        if (state_q == MST_SETUP) begin
            tmo_cnt_d = '0;
        end else if (state_q == MST_ACCESS && !bus.PREADY) begin
            tmo_cnt_d = tmo_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Timeout counter register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Fires on the edge that would bring the counter to TIMEOUT_CYCLES.
    assign tmo_hit_s = (state_q == MST_ACCESS) && !bus.PREADY &&
                       (tmo_cnt_q == CNTW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next state and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gidx_d       = gidx_q;
        paddr_d      = paddr_q;
        pprot_d      = pprot_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        req_ack_d    = '0;
        resp_valid_d = '0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            MST_IDLE: begin
                if (grant_any_s) begin
                    gidx_d    = grant_idx_s;
                    rr_ptr_d  = grant_idx_s;
                    req_ack_d = grant_s;
                    paddr_d   = sel_addr_s;
                    pwrite_d  = bus.req_write[grant_idx_s];
                    pwdata_d  = bus.req_wdata[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
                    pprot_d   = bus.req_prot[int'(grant_idx_s)*3 +: 3];
                    // Strobes carry no meaning on reads and are driven low.
                    pstrb_d   = bus.req_write[grant_idx_s] ?
                                bus.req_strb[int'(grant_idx_s)*PSTRB_WIDTH +: PSTRB_WIDTH] :
                                {PSTRB_WIDTH{1'b0}};
                    psel_d    = slave_sel(sel_addr_s[ADDR_WIDTH-1 -: 2]);
                    state_d   = MST_SETUP;
                end else begin
                    state_d   = MST_IDLE;
                end
            end
            MST_SETUP: begin
                penable_d = 1'b1;
                state_d   = MST_ACCESS;
            end
            MST_ACCESS: begin
                // PREADY wins over a timeout on the same edge.
                if (bus.PREADY) begin
                    psel_d               = 4'b0000;
                    penable_d            = 1'b0;
                    resp_valid_d[gidx_q] = 1'b1;
                    resp_err_d           = bus.PSLVERR;
                    resp_rdata_d         = pwrite_q ? {DATA_WIDTH{1'b0}} : bus.PRDATA;
                    state_d              = MST_IDLE;
                end else if (tmo_hit_s) begin
                    psel_d               = 4'b0000;
                    penable_d            = 1'b0;
                    resp_valid_d[gidx_q] = 1'b1;
                    resp_err_d           = 1'b1;
                    resp_rdata_d         = {DATA_WIDTH{1'b0}};
                    state_d              = MST_IDLE;
                end else begin
                    state_d              = MST_ACCESS;
                end
            end
            default: begin
                psel_d    = 4'b0000;
                penable_d = 1'b0;
                state_d   = MST_IDLE;
            end
        endcase
    end

    // State, arbitration pointer and output registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= MST_IDLE;
            rr_ptr_q     <= IDXW'(NUM_REQ - 1);
            gidx_q       <= '0;
            paddr_q      <= '0;
            pprot_q      <= 3'b000;
            psel_q       <= 4'b0000;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            req_ack_q    <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gidx_q       <= gidx_d;
            paddr_q      <= paddr_d;
            pprot_q      <= pprot_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            req_ack_q    <= req_ack_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.PADDR      = paddr_q;
    assign bus.PPROT      = pprot_q;
    assign bus.PSEL       = psel_q;
    assign bus.PENABLE    = penable_q;
    assign bus.PWRITE     = pwrite_q;
    assign bus.PWDATA     = pwdata_q;
    assign bus.PSTRB      = pstrb_q;
    assign bus.req_ack    = req_ack_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
// Directed vectors with hand-computed expectations for apb_master_arbiter
// (NUM_REQ = 2, 32-bit address/data). Outputs are sampled 1 time unit after
// the rising edge; inputs are changed at the same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_master_arbiter;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;
    int   tally;

    apb_master_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int idx, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
        bus.req_addr[idx*32 +: 32]  = addr;
        bus.req_write[idx]          = wr;
        bus.req_wdata[idx*32 +: 32] = wdata;
        bus.req_strb[idx*4 +: 4]    = strb;
        bus.req_prot[idx*3 +: 3]    = prot;
        bus.req_valid[idx]          = 1'b1;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_write = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.req_prot  = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();

        // Reset state
        check_eq("rst_psel", bus.PSEL, 4'h0);
        check_eq("rst_penable", bus.PENABLE, 1'b0);
        check_eq("rst_ack", bus.req_ack, 2'b00);
        check_eq("rst_resp_valid", bus.resp_valid, 2'b00);
        check_eq("rst_paddr", bus.PADDR, 32'h0);
        rst_n = 1'b1;
        step();

        // Single write from requester 0, zero wait states
        bus.PREADY = 1'b1;
        issue(0, 32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'h2);
        step();
        check_eq("wr_ack", bus.req_ack, 2'b01);
        check_eq("wr_setup_psel", bus.PSEL, 4'b0010);
        check_eq("wr_setup_penable", bus.PENABLE, 1'b0);
        check_eq("wr_paddr", bus.PADDR, 32'h4000_0010);
        check_eq("wr_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
        check_eq("wr_pstrb", bus.PSTRB, 4'hF);
        check_eq("wr_pwrite", bus.PWRITE, 1'b1);
        check_eq("wr_pprot", bus.PPROT, 3'h2);
        bus.req_valid[0] = 1'b0;
        step();
        check_eq("wr_access_psel", bus.PSEL, 4'b0010);
        check_eq("wr_access_penable", bus.PENABLE, 1'b1);
        check_eq("wr_ack_pulse", bus.req_ack, 2'b00);
        step();
        check_eq("wr_resp_valid", bus.resp_valid, 2'b01);
        check_eq("wr_resp_err", bus.resp_err, 1'b0);
        check_eq("wr_resp_rdata", bus.resp_rdata, 32'h0);
        check_eq("wr_idle_psel", bus.PSEL, 4'h0);
        check_eq("wr_idle_penable", bus.PENABLE, 1'b0);
        check_eq("wr_paddr_hold", bus.PADDR, 32'h4000_0010);

        // Read from requester 0 with 3 wait states
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h1234_5678;
        issue(0, 32'hC000_0004, 1'b0, 32'h5555_AAAA, 4'hF, 3'h0);
        step();
        check_eq("rd_ack", bus.req_ack, 2'b01);
        check_eq("rd_setup_psel", bus.PSEL, 4'b1000);
        check_eq("rd_pstrb", bus.PSTRB, 4'h0);
        check_eq("rd_pwrite", bus.PWRITE, 1'b0);
        bus.req_valid[0] = 1'b0;
        step();
        tally = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus.PENABLE === 1'b1 && bus.PSEL === 4'b1000 && bus.resp_valid === 2'b00) tally++;
            step();
        end
        if (bus.PENABLE === 1'b1 && bus.PSEL === 4'b1000) tally++;
        bus.PREADY = 1'b1;
        step();
        check_eq("rd_access_cycles", 64'(tally), 64'd4);
        check_eq("rd_resp_valid", bus.resp_valid, 2'b01);
        check_eq("rd_resp_rdata", bus.resp_rdata, 32'h1234_5678);
        check_eq("rd_resp_err", bus.resp_err, 1'b0);

        // PSLVERR on a read from requester 1 (pointer at 0, so 1 wins)
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hCAFE_F00D;
        issue(1, 32'h8000_0008, 1'b0, 32'h0, 4'hF, 3'h1);
        step();
        check_eq("err_ack", bus.req_ack, 2'b10);
        check_eq("err_psel", bus.PSEL, 4'b0100);
        bus.req_valid[1] = 1'b0;
        step();
        step();
        check_eq("err_resp_valid", bus.resp_valid, 2'b10);
        check_eq("err_resp_err", bus.resp_err, 1'b1);
        check_eq("err_resp_rdata", bus.resp_rdata, 32'hCAFE_F00D);
        bus.PSLVERR = 1'b0;

        // Both requesters held for 4 transfers: strict alternation 0,1,0,1
        issue(0, 32'h0000_0100, 1'b1, 32'h1111_1111, 4'h3, 3'h0);
        issue(1, 32'h8000_0200, 1'b1, 32'h2222_2222, 4'hC, 3'h0);
        for (int t = 0; t < 4; t++) begin
            step();
            check_eq($sformatf("rr%0d_ack", t), bus.req_ack, (t % 2 == 0) ? 2'b01 : 2'b10);
            check_eq($sformatf("rr%0d_psel", t), bus.PSEL, (t % 2 == 0) ? 4'b0001 : 4'b0100);
            check_eq($sformatf("rr%0d_pwdata", t), bus.PWDATA,
                     (t % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
            if (t == 3) bus.req_valid = 2'b00;
            step();
            check_eq($sformatf("rr%0d_ack_pulse", t), bus.req_ack, 2'b00);
            step();
            check_eq($sformatf("rr%0d_resp_valid", t), bus.resp_valid,
                     (t % 2 == 0) ? 2'b01 : 2'b10);
            check_eq($sformatf("rr%0d_idle_psel", t), bus.PSEL, 4'h0);
        end

        // Reset asserted during ACCESS aborts the transfer
        bus.PREADY = 1'b0;
        issue(1, 32'h4000_0020, 1'b1, 32'h3333_3333, 4'hF, 3'h0);
        step();
        check_eq("rst_mid_ack", bus.req_ack, 2'b10);
        bus.req_valid[1] = 1'b0;
        step();
        check_eq("rst_mid_penable_pre", bus.PENABLE, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_psel", bus.PSEL, 4'h0);
        check_eq("rst_mid_penable", bus.PENABLE, 1'b0);
        check_eq("rst_mid_paddr", bus.PADDR, 32'h0);
        check_eq("rst_mid_pwdata", bus.PWDATA, 32'h0);
        check_eq("rst_mid_pstrb", bus.PSTRB, 4'h0);
        check_eq("rst_mid_pwrite", bus.PWRITE, 1'b0);
        bus.PREADY = 1'b1;
        step();
        step();
        check_eq("rst_mid_resp_valid", bus.resp_valid, 2'b00);
        rst_n = 1'b1;
        issue(0, 32'h0000_0010, 1'b1, 32'h4444_4444, 4'hF, 3'h0);
        issue(1, 32'h4000_0030, 1'b1, 32'h5555_5555, 4'hF, 3'h0);
        step();
        check_eq("post_rst_ack", bus.req_ack, 2'b01);
        bus.req_valid = 2'b00;
        step();
        step();
        check_eq("post_rst_resp_valid", bus.resp_valid, 2'b01);

        // Slave never ready
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h0BAD_0BAD;
        issue(1, 32'h0000_0040, 1'b0, 32'h0, 4'hF, 3'h0);
        step();
        check_eq("stall_ack", bus.req_ack, 2'b10);
        bus.req_valid[1] = 1'b0;
        step();
        tally = 0;
`ifdef APB_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            if (bus.PENABLE === 1'b1 && bus.resp_valid === 2'b00) tally++;
            step();
        end
        check_eq("tmo_access_cycles", 64'(tally), 64'd16);
        check_eq("tmo_resp_valid", bus.resp_valid, 2'b10);
        check_eq("tmo_resp_err", bus.resp_err, 1'b1);
        check_eq("tmo_resp_rdata", bus.resp_rdata, 32'h0);
        check_eq("tmo_psel", bus.PSEL, 4'h0);
        check_eq("tmo_penable", bus.PENABLE, 1'b0);
        step();
        check_eq("tmo_idle_psel", bus.PSEL, 4'h0);
`else
        for (int k = 0; k < 20; k++) begin
            if (bus.PENABLE === 1'b1 && bus.PSEL === 4'b0001 && bus.resp_valid === 2'b00) tally++;
            step();
        end
        check_eq("stall_access_cycles", 64'(tally), 64'd20);
        check_eq("stall_penable", bus.PENABLE, 1'b1);
        bus.PREADY = 1'b1;
        step();
        check_eq("stall_resp_valid", bus.resp_valid, 2'b10);
        check_eq("stall_resp_err", bus.resp_err, 1'b0);
        check_eq("stall_resp_rdata", bus.resp_rdata, 32'h0BAD_0BAD);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
